// File: rtl/vedic_stream_master.sv
// vedic_stream_master: initiator-side handshake engine for the stream multipliers.
// Forks packed operand pairs onto the multiplier's A and B channels and tracks
// how many products are still awaiting a result. Results are collected into a
// 2-entry buffer toward the consumer.
// Optional feature: define VEDIC_MASTER_CHECK_EN to build a golden-model checker
// that compares each returned product with a*b and drives err / err_cnt.
module vedic_stream_master #(
  parameter int DATA_W          = 2,
  parameter int RES_W           = 2 * DATA_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [2*DATA_W-1:0] s_op_tdata,
  input  logic                s_op_tvalid,
  output logic                s_op_tready,
  output logic [DATA_W-1:0]   m_a_tdata,
  output logic                m_a_tvalid,
  input  logic                m_a_tready,
  output logic [DATA_W-1:0]   m_b_tdata,
  output logic                m_b_tvalid,
  input  logic                m_b_tready,
  input  logic [RES_W-1:0]    s_result_tdata,
  input  logic                s_result_tvalid,
  output logic                s_result_tready,
  output logic [RES_W-1:0]    m_out_tdata,
  output logic                m_out_tvalid,
  input  logic                m_out_tready,
  output logic [3:0]          outstanding,
  output logic                err,
  output logic [7:0]          err_cnt
);

  logic              a_pend, b_pend;
  logic [DATA_W-1:0] a_q, b_q;
  logic              op_hs, a_hs, b_hs, issue_done;
  logic              res_hs, out_hs, dec;
  logic [3:0]        outstanding_nxt;

  logic [RES_W-1:0]  fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;

  assign a_hs  = a_pend & m_a_tready;
  assign b_hs  = b_pend & m_b_tready;
  // The issue completes when every flag still pending clears on this edge.
  assign issue_done = (a_pend | b_pend) & (~a_pend | a_hs) & (~b_pend | b_hs);

  assign s_op_tready = arst_n & ~a_pend & ~b_pend &
                       (outstanding < 4'(MAX_OUTSTANDING));
  assign op_hs = s_op_tvalid & s_op_tready;

  assign m_a_tvalid = a_pend;
  assign m_b_tvalid = b_pend;
  assign m_a_tdata  = a_q;
  assign m_b_tdata  = b_q;

  assign s_result_tready = arst_n & (fifo_cnt != 2'd2);
  assign res_hs = s_result_tvalid & s_result_tready;
  // A result with nothing outstanding is spurious; the counter stays at 0.
  assign dec    = res_hs & (outstanding != 4'd0);

  assign m_out_tvalid = (fifo_cnt != 2'd0);
  assign m_out_tdata  = fifo_mem[rd_ptr];
  assign out_hs       = m_out_tvalid & m_out_tready;

  // Fork state: latch the pair and raise both pend flags; each clears on its own handshake.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!arst_n) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (op_hs) begin
      a_pend <= 1'b1;
      b_pend <= 1'b1;
      a_q    <= s_op_tdata[DATA_W-1:0];
      b_q    <= s_op_tdata[2*DATA_W-1:DATA_W];
    end else begin
      if (a_hs) a_pend <= 1'b0;
      if (b_hs) b_pend <= 1'b0;
    end
  end

  // Next value of the outstanding-product counter.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned and no latch is inferred.
    outstanding_nxt = outstanding;
    if (issue_done && !dec)      outstanding_nxt = outstanding + 4'd1;
    else if (dec && !issue_done) outstanding_nxt = outstanding - 4'd1;
  end

  // Outstanding-product counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) outstanding <= 4'd0;
    else         outstanding <= outstanding_nxt;
  end

  // Two-entry result buffer; a full buffer refuses pushes even when popping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: the buffer storage is reset here because m_out_tdata must read 0 while in reset.
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (res_hs) begin
        fifo_mem[wr_ptr] <= s_result_tdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_hs) rd_ptr <= ~rd_ptr;
      case ({res_hs, out_hs})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef VEDIC_MASTER_CHECK_EN
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [RES_W-1:0] exp_mem [MAX_OUTSTANDING];
  logic [PW-1:0]    exp_wr, exp_rd;
  logic [RES_W-1:0] exp_prod;
  logic             chk_err;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign exp_prod = RES_W'(s_op_tdata[DATA_W-1:0]) * RES_W'(s_op_tdata[2*DATA_W-1:DATA_W]);
  // Spurious results and wrong products both count as errors.
  assign chk_err  = (res_hs & (outstanding == 4'd0)) |
                    (dec & (s_result_tdata != exp_mem[exp_rd]));

  // Expected-product storage; entries are only read behind a valid write pointer.
  always_ff @(posedge clk) begin
    if (op_hs) exp_mem[exp_wr] <= exp_prod;
  end

  // Checker pointers plus sticky error flag and saturating error counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exp_wr  <= '0;
      exp_rd  <= '0;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      if (op_hs) exp_wr <= ptr_next(exp_wr);
      if (dec)   exp_rd <= ptr_next(exp_rd);
      if (chk_err) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vedic_stream_master.sv
// Testbench for vedic_stream_master: an ideal multiplier model answers the A/B
// channels, a scoreboard queue holds the products expected on m_out, and
// directed phases cover the timing corner cases before a randomized run.
module tb_vedic_stream_master;

  localparam int DATA_W  = 2;
  localparam int RES_W   = 2 * DATA_W;
  localparam int MAX_OUT = 4;

  logic                clk = 1'b0;
  logic                arst_n = 1'b0;
  logic [2*DATA_W-1:0] s_op_tdata = '0;
  logic                s_op_tvalid = 1'b0;
  logic                s_op_tready;
  logic [DATA_W-1:0]   m_a_tdata, m_b_tdata;
  logic                m_a_tvalid, m_b_tvalid;
  logic                m_a_tready = 1'b0;
  logic                m_b_tready = 1'b0;
  logic [RES_W-1:0]    s_result_tdata = '0;
  logic                s_result_tvalid = 1'b0;
  logic                s_result_tready;
  logic [RES_W-1:0]    m_out_tdata;
  logic                m_out_tvalid;
  logic                m_out_tready = 1'b0;
  logic [3:0]          outstanding;
  logic                err;
  logic [7:0]          err_cnt;

  vedic_stream_master #(
    .DATA_W(DATA_W), .RES_W(RES_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .s_op_tdata(s_op_tdata), .s_op_tvalid(s_op_tvalid), .s_op_tready(s_op_tready),
    .m_a_tdata(m_a_tdata), .m_a_tvalid(m_a_tvalid), .m_a_tready(m_a_tready),
    .m_b_tdata(m_b_tdata), .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready),
    .s_result_tdata(s_result_tdata), .s_result_tvalid(s_result_tvalid),
    .s_result_tready(s_result_tready),
    .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
    .outstanding(outstanding), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int out_cnt = 0;
  int n_pairs = 0;
  int n_results = 0;

  bit               rand_mode = 1'b0;
  bit               hold_res = 1'b0;
  bit               inject_en = 1'b0;
  logic [RES_W-1:0] inject_val = '0;

  logic [RES_W-1:0]  exp_q [$];
  logic [RES_W-1:0]  res_q [$];
  logic [DATA_W-1:0] ma_q [$];
  logic [DATA_W-1:0] mb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!arst_n) begin
      exp_q.delete(); res_q.delete(); ma_q.delete(); mb_q.delete();
      n_pairs = 0; n_results = 0;
    end else begin
      check("outstanding", {28'd0, outstanding}, n_pairs - n_results);
      if (s_op_tvalid && s_op_tready)
        exp_q.push_back(inject_en ? inject_val :
                        RES_W'(s_op_tdata[DATA_W-1:0]) * RES_W'(s_op_tdata[2*DATA_W-1:DATA_W]));
      if (m_out_tvalid && m_out_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: got %0d, no product expected", m_out_tdata);
        end else check("out_data", m_out_tdata, exp_q.pop_front());
      end
      if (m_a_tvalid && m_a_tready) ma_q.push_back(m_a_tdata);
      if (m_b_tvalid && m_b_tready) mb_q.push_back(m_b_tdata);
      while (ma_q.size() != 0 && mb_q.size() != 0) begin
        res_q.push_back(RES_W'(ma_q.pop_front()) * RES_W'(mb_q.pop_front()));
        n_pairs++;
      end
      if (s_result_tvalid && s_result_tready && res_q.size() != 0) begin
        void'(res_q.pop_front());
        n_results++;
      end
    end
  end

  // Stalled outputs must hold valid and data.
  logic [RES_W-1:0]  held_out;
  logic [DATA_W-1:0] held_a;
  bit                out_stalled = 1'b0;
  bit                a_stalled = 1'b0;
  always @(negedge clk) begin
    if (!arst_n) begin
      out_stalled = 1'b0;
      a_stalled   = 1'b0;
    end else begin
      if (out_stalled) begin
        check("out_hold_valid", m_out_tvalid, 1);
        check("out_hold_data", m_out_tdata, held_out);
      end
      if (a_stalled) begin
        check("a_hold_valid", m_a_tvalid, 1);
        check("a_hold_data", m_a_tdata, held_a);
      end
      out_stalled = m_out_tvalid && !m_out_tready;
      held_out    = m_out_tdata;
      a_stalled   = m_a_tvalid && !m_a_tready;
      held_a      = m_a_tdata;
    end
  end

  // Advance one cycle and drive the multiplier result side plus random readies.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      m_a_tready   = 1'($urandom_range(0, 1));
      m_b_tready   = 1'($urandom_range(0, 1));
      m_out_tready = 1'($urandom_range(0, 1));
    end
    s_result_tvalid = !hold_res && res_q.size() != 0 && (!rand_mode || $urandom_range(0, 3) != 0);
    s_result_tdata  = (res_q.size() != 0) ? (inject_en ? inject_val : res_q[0]) : '0;
  endtask

  task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bit done = 1'b0;
    s_op_tdata  = {b, a};
    s_op_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = s_op_tready;
      tick();
    end
    s_op_tvalid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL issue_timeout: pair a=%0d b=%0d not accepted", a, b);
    end
  endtask

  task automatic drain();
    int n = 0;
    m_a_tready = 1'b1; m_b_tready = 1'b1; m_out_tready = 1'b1; hold_res = 1'b0;
    while ((exp_q.size() != 0 || outstanding != 0 || m_a_tvalid || m_b_tvalid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL drain_timeout: %0d products still expected", exp_q.size());
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_op_ready", s_op_tready, 0);
    check("rst_res_ready", s_result_tready, 0);
    check("rst_a_valid", m_a_tvalid, 0);
    check("rst_out_valid", m_out_tvalid, 0);
    check("rst_outstanding", outstanding, 0);
    tick();
    arst_n = 1'b1;
    @(negedge clk);
    check("op_ready_after_reset", s_op_tready, 1);

    // Basic products with all readies high.
    tick();
    m_a_tready = 1'b1; m_b_tready = 1'b1; m_out_tready = 1'b1;
    base = out_cnt;
    issue(2'd3, 2'd2);
    issue(2'd3, 2'd3);
    issue(2'd1, 2'd2);
    drain();
    check("basic_out_count", out_cnt - base, 3);
    check("basic_outstanding", outstanding, 0);
    check("basic_err", err, 0);

    // Staggered channels: A at N+1, B at N+4.
    m_a_tready = 1'b0; m_b_tready = 1'b0;
    issue(2'd2, 2'd3);
    m_a_tready = 1'b1;
    @(negedge clk);
    check("stag_a_valid_n", m_a_tvalid, 1);
    check("stag_b_valid_n", m_b_tvalid, 1);
    check("stag_op_ready_n", s_op_tready, 0);
    tick();
    m_a_tready = 1'b0;
    @(negedge clk);
    check("stag_a_valid_n1", m_a_tvalid, 0);
    check("stag_b_valid_n1", m_b_tvalid, 1);
    check("stag_op_ready_n1", s_op_tready, 0);
    tick();
    @(negedge clk);
    check("stag_op_ready_n2", s_op_tready, 0);
    tick();
    m_b_tready = 1'b1;
    @(negedge clk);
    check("stag_op_ready_n3", s_op_tready, 0);
    check("stag_b_valid_n3", m_b_tvalid, 1);
    tick();
    m_b_tready = 1'b0;
    @(negedge clk);
    check("stag_b_valid_n4", m_b_tvalid, 0);
    check("stag_outstanding_n4", outstanding, 1);
    check("stag_op_ready_n4", s_op_tready, 1);
    tick();
    drain();

    // Outstanding limit with results withheld.
    hold_res = 1'b1;
    for (int k = 0; k < MAX_OUT; k++)
      issue(DATA_W'($urandom), DATA_W'($urandom));
    tick();
    @(negedge clk);
    check("lim_outstanding", outstanding, 4);
    check("lim_op_ready", s_op_tready, 0);
    tick();
    hold_res = 1'b0;
    tick();
    hold_res = 1'b1;
    @(negedge clk);
    check("lim_res_ready", s_result_tready, 1);
    check("lim_outstanding_pre", outstanding, 4);
    tick();
    @(negedge clk);
    check("lim_outstanding_after", outstanding, 3);
    check("lim_op_ready_after", s_op_tready, 1);
    check("lim_out_valid", m_out_tvalid, 1);
    tick();
    drain();

    // Output back-pressure: only two results absorbed.
    hold_res = 1'b1;
    m_out_tready = 1'b0;
    for (int k = 0; k < 3; k++)
      issue(DATA_W'($urandom), DATA_W'($urandom));
    tick();
    hold_res = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("bp_res_ready_full", s_result_tready, 0);
    check("bp_out_valid", m_out_tvalid, 1);
    check("bp_outstanding", outstanding, 1);
    tick();
    m_out_tready = 1'b1;
    tick();
    m_out_tready = 1'b0;
    @(negedge clk);
    check("bp_res_ready_after_pop", s_result_tready, 1);
    check("bp_outstanding_after_pop", outstanding, 1);
    tick();
    @(negedge clk);
    check("bp_outstanding_third", outstanding, 0);
    check("bp_res_ready_refull", s_result_tready, 0);
    tick();
    drain();

    // Checker behaviour on a wrong product.
`ifdef VEDIC_MASTER_CHECK_EN
    inject_val = 4'd5;
    inject_en  = 1'b1;
    issue(2'd3, 2'd3);
    drain();
    inject_en = 1'b0;
    check("chk_err_set", err, 1);
    check("chk_err_cnt", err_cnt, 1);
    issue(2'd1, 2'd2);
    drain();
    check("chk_err_sticky", err, 1);
    check("chk_err_cnt_hold", err_cnt, 1);
`else
    issue(2'd3, 2'd3);
    drain();
    check("nochk_err", err, 0);
    check("nochk_err_cnt", err_cnt, 0);
`endif

    // Reset mid-operation with A pending and one buffered result.
    m_out_tready = 1'b0;
    issue(2'd2, 2'd2);
    for (int n = 0; n < 20 && !m_out_tvalid; n++) tick();
    m_a_tready = 1'b0; m_b_tready = 1'b0;
    issue(2'd1, 2'd3);
    @(negedge clk);
    check("rmid_pre_a_valid", m_a_tvalid, 1);
    check("rmid_pre_out_valid", m_out_tvalid, 1);
    #2;
    arst_n = 1'b0;
    #1;
    check("rmid_a_valid", m_a_tvalid, 0);
    check("rmid_b_valid", m_b_tvalid, 0);
    check("rmid_out_valid", m_out_tvalid, 0);
    check("rmid_op_ready", s_op_tready, 0);
    check("rmid_res_ready", s_result_tready, 0);
    check("rmid_outstanding", outstanding, 0);
    check("rmid_err", err, 0);
    check("rmid_err_cnt", err_cnt, 0);
    check("rmid_out_data", m_out_tdata, 0);
    check("rmid_a_data", m_a_tdata, 0);
    tick();
    tick();
    arst_n = 1'b1;
    @(negedge clk);
    check("rmid_op_ready_release", s_op_tready, 1);
    check("rmid_out_valid_release", m_out_tvalid, 0);
    tick();

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      s_op_tvalid = 1'($urandom_range(0, 1));
      s_op_tdata  = (2*DATA_W)'($urandom);
      tick();
    end
    s_op_tvalid = 1'b0;
    rand_mode   = 1'b0;
    drain();
    check("final_outstanding", outstanding, 0);
    check("final_err", err, 0);
    check("final_out_valid", m_out_tvalid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
